// File: rtl/sr_latch_driver.sv
// ---------------------------------------------------------------------------
// sr_latch_driver
//
// Writer side of an external cross-coupled NOR set/reset latch. Single-cycle
// set/clear requests from clocked logic become clean, mutually exclusive s/r
// pulses. Each pulse is exactly PW cycles wide and is followed by GUARD
// dead-time cycles. The block also tracks the latch value that the most recent
// completed pulse should have left behind (exp_q).
//
// Parameters
//   PW       s/r pulse width in clock cycles (>= 1)
//   GUARD    dead-time cycles after each pulse, s = r = 0 (>= 1)
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset; forces a clear pulse
//   set_req   in   request a set pulse (sampled only while ready = 1)
//   clr_req   in   request a clear pulse (sampled only while ready = 1)
//   s         out  latch set drive (registered)
//   r         out  latch reset drive (registered)
//   ready     out  high when a request can be accepted
//   exp_q     out  expected latch q after the last completed pulse
//   conflict  out  one-cycle flag: set_req and clr_req together while ready
//   q_fb      in   latch q feedback (readback builds only)
//   qb_fb     in   latch qb feedback (readback builds only)
//   fault     out  sticky readback mismatch flag
//
// Build option
//   SR_DRV_READBACK_EN  when defined, q_fb/qb_fb are synchronised and compared
//                       against exp_q while idle; a mismatch sets the sticky
//                       fault flag. When undefined, the feedback ports are
//                       ignored and fault is tied low.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | waiting for a request, ready = 1, s = r = 0
// SET    | s = 1 for PW cycles
// CLR    | r = 1 for PW cycles (also the reset state)
// GUARD  | dead time, s = r = 0 for GUARD cycles
// ---------------------------------------------------------------------------
module sr_latch_driver #(
    parameter int PW    = 4,
    parameter int GUARD = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_req,
    input  logic clr_req,
    output logic s,
    output logic r,
    output logic ready,
    output logic exp_q,
    output logic conflict,
    input  logic q_fb,
    input  logic qb_fb,
    output logic fault
);

    localparam int MAX_CNT = (PW > GUARD) ? PW : GUARD;
    localparam int CW      = $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0] PW_C    = CW'(PW);
    localparam logic [CW-1:0] GUARD_C = CW'(GUARD);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SET   = 2'd1,
        ST_CLR   = 2'd2,
        ST_GUARD = 2'd3
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;

    // The counter holds the number of edges already spent in the current
    // state; every entry loads 1 and the state ends on the edge where it
    // equals the programmed length. Reset clears it to 0 instead, so the
    // reset-initiated clear pulse keeps r high for PW full cycles after the
    // first edge with rst_n released (one edge longer than a normal pulse).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_CLR;
            cnt      <= '0;
            s        <= 1'b0;
            r        <= 1'b1;
            ready    <= 1'b0;
            exp_q    <= 1'b0;
            conflict <= 1'b0;
        end else begin
            conflict <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (set_req && !clr_req) begin
                        state <= ST_SET;
                        cnt   <= ONE_C;
                        s     <= 1'b1;
                        ready <= 1'b0;
                    end else if (clr_req && !set_req) begin
                        state <= ST_CLR;
                        cnt   <= ONE_C;
                        r     <= 1'b1;
                        ready <= 1'b0;
                    end else if (set_req && clr_req) begin
                        conflict <= 1'b1;
                    end
                end

                ST_SET: begin
                    if (cnt == PW_C) begin
                        state <= ST_GUARD;
                        cnt   <= ONE_C;
                        s     <= 1'b0;
                        exp_q <= 1'b1;
                    end else begin
                        cnt <= cnt + ONE_C;
                    end
                end

                ST_CLR: begin
                    if (cnt == PW_C) begin
                        state <= ST_GUARD;
                        cnt   <= ONE_C;
                        r     <= 1'b0;
                        exp_q <= 1'b0;
                    end else begin
                        cnt <= cnt + ONE_C;
                    end
                end

                ST_GUARD: begin
                    if (cnt == GUARD_C) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        ready <= 1'b1;
                    end else begin
                        cnt <= cnt + ONE_C;
                    end
                end

                default: begin
                    // Unreachable with a 2-bit enum; recover through dead time
                    // with both drives released.
                    state <= ST_GUARD;
                    cnt   <= ONE_C;
                    s     <= 1'b0;
                    r     <= 1'b0;
                    ready <= 1'b0;
                end
            endcase
        end
    end

`ifdef SR_DRV_READBACK_EN
    // Feedback comes straight from an asynchronous latch, so both rails get
    // a two-flop synchroniser before being compared. Reset values match the
    // cleared latch (q = 0, qb = 1) that reset itself produces.
    logic [1:0] q_sync;
    logic [1:0] qb_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_sync  <= 2'b00;
            qb_sync <= 2'b11;
            fault   <= 1'b0;
        end else begin
            q_sync  <= {q_sync[0], q_fb};
            qb_sync <= {qb_sync[0], qb_fb};
            // Only judged while idle: during a pulse or its dead time the
            // latch legitimately differs from exp_q.
            if ((state == ST_IDLE) &&
                ({q_sync[1], qb_sync[1]} != {exp_q, ~exp_q})) begin
                fault <= 1'b1;
            end
        end
    end
`else
    logic unused_fb;
    assign unused_fb = q_fb ^ qb_fb;
    assign fault     = 1'b0;
`endif

endmodule

// File: tb/tb_sr_latch_driver.sv
module tb_sr_latch_driver;

    localparam int PW    = 4;
    localparam int GUARD = 2;

    logic clk;
    logic rst_n;
    logic set_req;
    logic clr_req;
    logic s;
    logic r;
    logic ready;
    logic exp_q;
    logic conflict;
    logic q_fb;
    logic qb_fb;
    logic fault;

    int n_cmp = 0;
    int n_err = 0;

    sr_latch_driver #(.PW(PW), .GUARD(GUARD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_req  (set_req),
        .clr_req  (clr_req),
        .s        (s),
        .r        (r),
        .ready    (ready),
        .exp_q    (exp_q),
        .conflict (conflict),
        .q_fb     (q_fb),
        .qb_fb    (qb_fb),
        .fault    (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ideal NOR latch driven by the DUT, with an override that pins the
    // feedback to the cleared value regardless of what s/r did.
    logic latch_q = 1'b0;
    logic bad_fb  = 1'b0;
    always @(s or r) begin
        if (s === 1'b1)      latch_q = 1'b1;
        else if (r === 1'b1) latch_q = 1'b0;
    end
    assign q_fb  = bad_fb ? 1'b0 : latch_q;
    assign qb_fb = bad_fb ? 1'b1 : ~latch_q;

    // Reference model: remembers the edge at which the current pulse was
    // accepted and derives every output from the distance to that edge.
    int n      = 0;
    int m_acc  = 0;
    bit m_kind = 1'b0;   // 1 = set pulse, 0 = clear pulse
    bit m_base = 1'b0;   // exp_q before the current pulse completes
    bit m_inrst = 1'b1;
    bit m_s, m_r, m_ready, m_expq, m_conf;

    task automatic model_outputs();
        int d;
        if (m_inrst) begin
            m_s = 1'b0; m_r = 1'b1; m_ready = 1'b0; m_expq = 1'b0;
        end else begin
            d       = n - m_acc;
            m_s     = m_kind && (d < PW);
            m_r     = !m_kind && (d < PW);
            m_ready = (d >= PW + GUARD);
            m_expq  = (d >= PW) ? m_kind : m_base;
        end
    endtask

    task automatic model_edge();
        n++;
        m_conf = 1'b0;
        if (!rst_n) begin
            m_inrst = 1'b1;
        end else if (m_inrst) begin
            m_inrst = 1'b0; m_acc = n; m_kind = 1'b0; m_base = 1'b0;
        end else if (m_ready) begin
            if (set_req && clr_req) begin
                m_conf = 1'b1;
            end else if (set_req || clr_req) begin
                m_base = m_expq; m_acc = n; m_kind = set_req;
            end
        end
        model_outputs();
    endtask

    task automatic model_async_reset();
        m_inrst = 1'b1;
        m_conf  = 1'b0;
        model_outputs();
    endtask

    // Drive inputs on the falling edge, advance one rising edge, settle.
    task automatic cycle(input logic sr, input logic cr);
        @(negedge clk);
        set_req = sr;
        clr_req = cr;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        logic [5:0] want;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0);
            n_cmp++;
            if ({s, r, ready, exp_q, conflict, fault} !== 6'b010000) begin
                n_err++;
                $display("FAIL reset_hold[%0d]: got s,r,rdy,q,cf,flt=%b want 010000", i,
                         {s, r, ready, exp_q, conflict, fault});
            end
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            cycle(1'b0, 1'b0);
            want = {1'b0, (i <= PW) ? 1'b1 : 1'b0, (i >= PW + GUARD + 1) ? 1'b1 : 1'b0, 3'b000};
            n_cmp++;
            if ({s, r, ready, exp_q, conflict, fault} !== want) begin
                n_err++;
                $display("FAIL reset_release[%0d]: got %b want %b", i,
                         {s, r, ready, exp_q, conflict, fault}, want);
            end
        end
    endtask

    task automatic test_set_pulse();
        logic [3:0] want;
        for (int j = 0; j < 8; j++) begin
            if (j == 0) cycle(1'b1, 1'b0);
            else        cycle(1'b0, 1'b0);
            want = {(j < PW) ? 1'b1 : 1'b0, 1'b0, (j >= PW + GUARD) ? 1'b1 : 1'b0,
                    (j >= PW) ? 1'b1 : 1'b0};
            n_cmp++;
            if ({s, r, ready, exp_q} !== want) begin
                n_err++;
                $display("FAIL set_pulse[%0d]: got s,r,rdy,q=%b want %b", j,
                         {s, r, ready, exp_q}, want);
            end
        end
    endtask

    task automatic test_conflict();
        cycle(1'b1, 1'b1);
        n_cmp++;
        if ({s, r, ready, exp_q, conflict} !== 5'b00111) begin
            n_err++;
            $display("FAIL conflict_flag: got s,r,rdy,q,cf=%b want 00111",
                     {s, r, ready, exp_q, conflict});
        end
        cycle(1'b0, 1'b0);
        n_cmp++;
        if ({s, r, ready, exp_q, conflict} !== 5'b00110) begin
            n_err++;
            $display("FAIL conflict_one_cycle: got s,r,rdy,q,cf=%b want 00110",
                     {s, r, ready, exp_q, conflict});
        end
    endtask

    task automatic test_drop_during_busy();
        logic [3:0] want;
        // Clear first so the following set visibly moves exp_q.
        for (int j = 0; j < 8; j++) begin
            if (j == 0) cycle(1'b0, 1'b1);
            else        cycle(1'b0, 1'b0);
            want = {1'b0, (j < PW) ? 1'b1 : 1'b0, (j >= PW + GUARD) ? 1'b1 : 1'b0,
                    (j < PW) ? 1'b1 : 1'b0};
            n_cmp++;
            if ({s, r, ready, exp_q} !== want) begin
                n_err++;
                $display("FAIL clr_pulse[%0d]: got s,r,rdy,q=%b want %b", j,
                         {s, r, ready, exp_q}, want);
            end
        end
        for (int j = 0; j < 8; j++) begin
            if (j == 0)      cycle(1'b1, 1'b0);
            else if (j == 2) cycle(1'b0, 1'b1);
            else             cycle(1'b0, 1'b0);
            want = {(j < PW) ? 1'b1 : 1'b0, 1'b0, (j >= PW + GUARD) ? 1'b1 : 1'b0,
                    (j >= PW) ? 1'b1 : 1'b0};
            n_cmp++;
            if ({s, r, ready, exp_q} !== want) begin
                n_err++;
                $display("FAIL drop_clr[%0d]: got s,r,rdy,q=%b want %b", j,
                         {s, r, ready, exp_q}, want);
            end
        end
    endtask

    task automatic test_reset_mid_pulse();
        logic [3:0] want;
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        model_async_reset();
        #1;
        n_cmp++;
        if ({s, r, ready, exp_q, conflict, fault} !== 6'b010000) begin
            n_err++;
            $display("FAIL async_reset: got s,r,rdy,q,cf,flt=%b want 010000",
                     {s, r, ready, exp_q, conflict, fault});
        end
        cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        n_cmp++;
        if ({s, r, ready, exp_q} !== 4'b0100) begin
            n_err++;
            $display("FAIL reset_held: got s,r,rdy,q=%b want 0100", {s, r, ready, exp_q});
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b0, 1'b0);
            want = {1'b0, (i <= PW) ? 1'b1 : 1'b0, (i >= PW + GUARD + 1) ? 1'b1 : 1'b0, 1'b0};
            n_cmp++;
            if ({s, r, ready, exp_q} !== want) begin
                n_err++;
                $display("FAIL mid_reset_release[%0d]: got s,r,rdy,q=%b want %b", i,
                         {s, r, ready, exp_q}, want);
            end
        end
    endtask

    task automatic test_random();
        logic sr, cr;
        for (int i = 0; i < 600; i++) begin
            sr = ($urandom_range(0, 3) == 0);
            cr = ($urandom_range(0, 3) == 0);
            cycle(sr, cr);
            n_cmp++;
            if ({s, r, ready, exp_q, conflict, fault} !==
                {m_s, m_r, m_ready, m_expq, m_conf, 1'b0}) begin
                n_err++;
                $display("FAIL random[%0d]: got s,r,rdy,q,cf,flt=%b want %b", i,
                         {s, r, ready, exp_q, conflict, fault},
                         {m_s, m_r, m_ready, m_expq, m_conf, 1'b0});
            end
        end
    endtask

    task automatic test_readback();
        bit found;
        bit got;
        // Settle into idle first.
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            cycle(1'b0, 1'b0);
            if (ready === 1'b1) found = 1'b1;
        end
        bad_fb = 1'b1;
`ifdef SR_DRV_READBACK_EN
        cycle(1'b1, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            cycle(1'b0, 1'b0);
            if (ready === 1'b1) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL rb_ready_timeout: got ready=%b want 1 within 12 cycles", ready);
        end
        got = (fault === 1'b1);
        for (int i = 0; i < 3 && !got; i++) begin
            cycle(1'b0, 1'b0);
            if (fault === 1'b1) got = 1'b1;
        end
        n_cmp++;
        if (!got) begin
            n_err++;
            $display("FAIL rb_fault_set: got fault=%b want 1 within 3 cycles of ready", fault);
        end
        bad_fb = 1'b0;
        cycle(1'b0, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0);
        n_cmp++;
        if ({fault, exp_q, ready} !== 3'b101) begin
            n_err++;
            $display("FAIL rb_fault_sticky: got fault,q,rdy=%b want 101", {fault, exp_q, ready});
        end
        #2;
        rst_n = 1'b0;
        model_async_reset();
        #1;
        n_cmp++;
        if (fault !== 1'b0) begin
            n_err++;
            $display("FAIL rb_fault_reset: got fault=%b want 0", fault);
        end
        cycle(1'b0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0);
        n_cmp++;
        if ({fault, ready} !== 2'b01) begin
            n_err++;
            $display("FAIL rb_after_reset: got fault,rdy=%b want 01", {fault, ready});
        end
`else
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) cycle(1'b1, 1'b0);
            else        cycle(1'b0, 1'b0);
            if (fault !== 1'b0) got = 1'b1;
        end
        n_cmp++;
        if (got) begin
            n_err++;
            $display("FAIL no_readback_fault: got fault=1 want 0 with mismatched feedback");
        end
        n_cmp++;
        if ({exp_q, ready} !== 2'b11) begin
            n_err++;
            $display("FAIL no_readback_set: got q,rdy=%b want 11", {exp_q, ready});
        end
        bad_fb = 1'b0;
`endif
    endtask

    initial begin
        rst_n   = 1'b0;
        set_req = 1'b0;
        clr_req = 1'b0;
        test_reset();
        test_set_pulse();
        test_conflict();
        test_drop_during_busy();
        test_reset_mid_pulse();
        test_random();
        test_readback();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
